alu_16: RTL and testbench



---
 rtl/alu16_pkg.sv | 17 +
 rtl/mult16_seq.sv | 66 ++++++
 rtl/alu_16.sv | 47 ++++
 tb/tb_alu_16.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// alu16_pkg: shared opcodes, multiplier states and iteration count for alu_16.
// Contents: opcode_e (3-bit ALU select), mult_state_e (IDLE/RUN/DONE),
// MULT_ITERS (shift-add iterations per multiply).
package alu16_pkg;
    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_MULT = 3'b010,
        OP_XOR  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_SLT  = 3'b110,
        OP_NOR  = 3'b111
    } opcode_e;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_e;
    localparam int MULT_ITERS = 16;
endpackage

// File: rtl/mult16_seq.sv
// mult16_seq: sequential shift-add multiplier producing the low WIDTH bits of a*b.
// Ports: clk, rst_n (async active-low), i_start (opcode is MULT), i_a/i_b operands,
// o_product (product register), o_busy (high while iterating).
module mult16_seq
    import alu16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_product,
    output logic             o_busy
);
    localparam int CNT_W = $clog2(MULT_ITERS);
    mult_state_e      r_state, w_state_nxt;
    logic [WIDTH-1:0] r_a, r_b, r_mcand, r_mplier, r_acc, r_prod, w_acc_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             w_chg, w_load, w_step, w_last;
    // Operands are compared against the latched copy so a change in RUN or DONE
    // restarts the multiply from a fresh load.
    assign w_chg     = (i_a != r_a) || (i_b != r_b);
    assign w_load    = i_start && (r_state == IDLE || w_chg);
    assign w_step    = i_start && r_state == RUN && !w_chg;
    assign w_last    = w_step && r_cnt == CNT_W'(MULT_ITERS - 1);
    assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign o_product = r_prod;
    assign o_busy    = r_state == RUN;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = !i_start ? IDLE :
                      w_load   ? RUN  :
                      w_last   ? DONE : r_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (w_load) begin
            r_a      <= i_a;
            r_b      <= i_b;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
        end else if (w_step) begin
            r_acc    <= w_acc_nxt;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + 1'b1;
            if (w_last) r_prod <= w_acc_nxt;
        end
    end
endmodule

// File: rtl/alu_16.sv
// alu_16: eight-function 16-bit ALU; all ops combinational except a sequential multiply.
// Ports: clk, rst_n (async active-low), a/b operands, s2/s1/s0 opcode select,
// out (result), busy (multiply in progress).
module alu_16
    import alu16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s2,
    input  logic             s1,
    input  logic             s0,
    output logic [WIDTH-1:0] out,
    output logic             busy
);
    opcode_e          w_op;
    logic [WIDTH-1:0] w_product;
    logic             w_slt;
    assign w_op  = opcode_e'({s2, s1, s0});
    assign w_slt = $signed(a) < $signed(b);
    mult16_seq #(.WIDTH(WIDTH)) u_mult (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (w_op == OP_MULT),
        .i_a      (a),
        .i_b      (b),
        .o_product(w_product),
        .o_busy   (busy)
    );
    always_comb begin
        out = '0;
        case (w_op)
            OP_ADD:  out = a + b;
            OP_SUB:  out = a - b;
            OP_MULT: out = w_product;
            OP_XOR:  out = a ^ b;
            OP_AND:  out = a & b;
            OP_OR:   out = a | b;
            OP_SLT:  out = {{(WIDTH-1){1'b0}}, w_slt};
            OP_NOR:  out = ~(a | b);
            default: out = '0;
        endcase
    end
endmodule

// File: tb/tb_alu_16.sv
// tb_alu_16: directed self-checking bench for alu_16.
module tb_alu_16;
    import alu16_pkg::*;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] a = '0, b = '0, out;
    logic        s2 = 1'b0, s1 = 1'b0, s0 = 1'b0, busy;
    int          checks = 0, errors = 0;

    alu_16 dut (
        .clk  (clk),
        .rst_n(rst_n),
        .a    (a),
        .b    (b),
        .s2   (s2),
        .s1   (s1),
        .s0   (s0),
        .out  (out),
        .busy (busy)
    );

    always #5 clk = ~clk;

    task automatic apply(input logic [2:0] op, input logic [15:0] va, input logic [15:0] vb);
        {s2, s1, s0} = op;
        a = va;
        b = vb;
    endtask

    task automatic test_reset();
        apply(OP_MULT, 16'h1234, 16'h0005);
        #1;
        checks++;
        if (out !== 16'h0000) begin errors++; $display("FAIL reset_out out=%h expected=%h", out, 16'h0000); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy busy=%b expected=0", busy); end
        apply(OP_ADD, 16'h0001, 16'h0002);
        #1;
        checks++;
        if (out !== 16'h0003) begin errors++; $display("FAIL reset_comb out=%h expected=%h", out, 16'h0003); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        logic [15:0] va[2] = '{16'h5BF3, 16'h0000};
        logic [15:0] vb[2] = '{16'h0011, 16'h5678};
        logic [15:0] ve[2] = '{16'h5C04, 16'h5678};
        for (int i = 0; i < 2; i++) begin
            apply(OP_ADD, va[i], vb[i]);
            #1;
            checks++;
            if (out !== ve[i]) begin errors++; $display("FAIL add[%0d] out=%h expected=%h", i, out, ve[i]); end
        end
    endtask

    task automatic test_sub();
        logic [15:0] va[3] = '{16'hAF23, 16'hFFFF, 16'h0000};
        logic [15:0] vb[3] = '{16'h0023, 16'hFFFF, 16'h0001};
        logic [15:0] ve[3] = '{16'hAF00, 16'h0000, 16'hFFFF};
        for (int i = 0; i < 3; i++) begin
            apply(OP_SUB, va[i], vb[i]);
            #1;
            checks++;
            if (out !== ve[i]) begin errors++; $display("FAIL sub[%0d] out=%h expected=%h", i, out, ve[i]); end
        end
    endtask

    task automatic test_logic();
        logic [2:0]  vo[8] = '{OP_XOR, OP_XOR, OP_AND, OP_AND, OP_OR, OP_OR, OP_NOR, OP_NOR};
        logic [15:0] va[8] = '{16'h0101, 16'h9999, 16'h0000, 16'h2ABF, 16'h0000, 16'h2ABF, 16'h0000, 16'h2ABF};
        logic [15:0] vb[8] = '{16'hFFFF, 16'h0000, 16'h1234, 16'h2ABF, 16'h1234, 16'h2ABF, 16'h1234, 16'h2ABF};
        logic [15:0] ve[8] = '{16'hFEFE, 16'h9999, 16'h0000, 16'h2ABF, 16'h1234, 16'h2ABF, 16'hEDCB, 16'hD540};
        for (int i = 0; i < 8; i++) begin
            apply(vo[i], va[i], vb[i]);
            #1;
            checks++;
            if (out !== ve[i]) begin errors++; $display("FAIL logic[%0d] op=%b out=%h expected=%h", i, vo[i], out, ve[i]); end
        end
    endtask

    task automatic test_slt();
        logic [15:0] va[4] = '{16'h3BFC, 16'h000F, 16'h8000, 16'h0001};
        logic [15:0] vb[4] = '{16'h4212, 16'h0001, 16'h0001, 16'h8000};
        logic [15:0] ve[4] = '{16'h0001, 16'h0000, 16'h0001, 16'h0000};
        for (int i = 0; i < 4; i++) begin
            apply(OP_SLT, va[i], vb[i]);
            #1;
            checks++;
            if (out !== ve[i]) begin errors++; $display("FAIL slt[%0d] out=%h expected=%h", i, out, ve[i]); end
        end
    endtask

    // Each vector follows the previous one with different operands, so from the
    // second vector on the multiplier restarts out of DONE.
    task automatic test_mult();
        logic [15:0] va[6] = '{16'h0002, 16'h0000, 16'h0100, 16'h1234, 16'hFFFF, 16'h00FF};
        logic [15:0] vb[6] = '{16'h0003, 16'h5678, 16'h0100, 16'h0005, 16'hFFFF, 16'h0101};
        logic [15:0] ve[6] = '{16'h0006, 16'h0000, 16'h0000, 16'h5B04, 16'h0001, 16'hFFFF};
        apply(OP_ADD, 16'h0000, 16'h0000);
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            apply(OP_MULT, va[i], vb[i]);
            for (int e = 1; e <= 17; e++) begin
                @(posedge clk);
                #1;
                checks++;
                if (busy !== (e < 17)) begin errors++; $display("FAIL mult[%0d]_busy edge=%0d busy=%b expected=%b", i, e, busy, e < 17); end
                checks++;
                if (out !== (e < 17 ? 16'h0000 : ve[i])) begin
                    errors++;
                    $display("FAIL mult[%0d]_out edge=%0d out=%h expected=%h", i, e, out, e < 17 ? 16'h0000 : ve[i]);
                end
            end
            repeat (3) @(posedge clk);
            #1;
            checks++;
            if (out !== ve[i] || busy !== 1'b0) begin errors++; $display("FAIL mult[%0d]_hold out=%h busy=%b expected=%h/0", i, out, busy, ve[i]); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_abort();
        apply(OP_ADD, 16'h0000, 16'h0000);
        @(negedge clk);
        apply(OP_MULT, 16'h1234, 16'h0005);
        repeat (6) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || out !== 16'h0000) begin errors++; $display("FAIL abort_rst busy=%b out=%h expected=0/0000", busy, out); end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 17; e++) begin
            @(posedge clk);
            #1;
            checks++;
            if (busy !== (e < 17)) begin errors++; $display("FAIL abort_rst_busy edge=%0d busy=%b expected=%b", e, busy, e < 17); end
        end
        checks++;
        if (out !== 16'h5B04) begin errors++; $display("FAIL abort_rst_result out=%h expected=%h", out, 16'h5B04); end
    endtask

    task automatic test_abort_add();
        apply(OP_ADD, 16'h0000, 16'h0000);
        @(negedge clk);
        apply(OP_MULT, 16'h0007, 16'h0009);
        repeat (4) @(posedge clk);
        @(negedge clk);
        apply(OP_ADD, 16'h0007, 16'h0009);
        #1;
        checks++;
        if (out !== 16'h0010) begin errors++; $display("FAIL abort_add_out out=%h expected=%h", out, 16'h0010); end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL abort_add_busy_before busy=%b expected=1", busy); end
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_add_busy_after busy=%b expected=0", busy); end
        checks++;
        if (out !== 16'h0010) begin errors++; $display("FAIL abort_add_out_after out=%h expected=%h", out, 16'h0010); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_logic();
        test_slt();
        test_mult();
        test_reset_abort();
        test_abort_add();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
